// File: rtl/mem_req_arbiter_if.sv
// Bundle of channel-side and cache-side signals for mem_req_arbiter.
// slave  : the arbiter's view (requests in, acks and cache request out).
// master : the requesters' and cache's view (the opposite directions).
interface mem_req_arbiter_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int ID_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]        ch_req_i;
    logic [NUM_CH-1:0]        ch_we_i;
    logic [NUM_CH*ADDR_W-1:0] ch_addr_i;
    logic [NUM_CH*DATA_W-1:0] ch_wdata_i;
    logic [NUM_CH-1:0]        ch_ack_o;
    logic [DATA_W-1:0]        ch_rdata_o;
    logic                     mem_req_o;
    logic                     mem_we_o;
    logic [ADDR_W-1:0]        mem_addr_o;
    logic [DATA_W-1:0]        mem_wdata_o;
    logic                     mem_ack_i;
    logic [DATA_W-1:0]        mem_rdata_i;
    logic [ID_W-1:0]          grant_id_o;

    modport slave (
        input  ch_req_i, ch_we_i, ch_addr_i, ch_wdata_i, mem_ack_i, mem_rdata_i,
        output ch_ack_o, ch_rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
               grant_id_o
    );

    modport master (
        output ch_req_i, ch_we_i, ch_addr_i, ch_wdata_i, mem_ack_i, mem_rdata_i,
        input  ch_ack_o, ch_rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
               grant_id_o
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one data-cache port between NUM_CH requesting
// channels, one transaction at a time, with round-robin arbitration.
// Optional macro MEM_ARB_PRIO0_EN: channel 0 (page-table walker) gets fixed
// priority over the others and never moves the round-robin pointer.
module mem_req_arbiter #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    mem_req_arbiter_if.slave  bus
);
    localparam int ID_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   winner;
    logic              ptr_update;
    logic              any_req;
    logic [NUM_CH-1:0] masked_req;
    logic              found;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rdata_q;

    assign any_req = |bus.ch_req_i;

    // Arbitration: requests above the pointer win first, otherwise wrap to the lowest requester.
    always_comb begin
        masked_req = '0;
        winner     = '0;
        found      = 1'b0;
        sel_we     = 1'b0;
        sel_addr   = '0;
        sel_wdata  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ID_W'(i) > ptr) begin
                masked_req[i] = bus.ch_req_i[i];
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (masked_req[i] && !found) begin
                winner = ID_W'(i);
                found  = 1'b1;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.ch_req_i[i] && !found) begin
                winner = ID_W'(i);
                found  = 1'b1;
            end
        end
`ifdef MEM_ARB_PRIO0_EN
        if (bus.ch_req_i[0]) begin
            winner = '0;
        end
        ptr_update = (winner != '0);
`else
        ptr_update = 1'b1;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (winner == ID_W'(i)) begin
                sel_we    = bus.ch_we_i[i];
                sel_addr  = bus.ch_addr_i[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.ch_wdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: grant when anyone asks, wait for the cache, then one ack cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = BUSY;
            BUSY:    if (bus.mem_ack_i) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Grant bookkeeping and request/response capture; fields only load on a grant so later request changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= ID_W'(NUM_CH - 1);
            grant_id  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                grant_id  <= winner;
                mem_we    <= sel_we;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                if (ptr_update) begin
                    ptr <= winner;
                end
            end
            if (state == BUSY && bus.mem_ack_i) begin
                rdata_q <= bus.mem_rdata_i;
            end
        end
    end

    assign bus.mem_req_o   = (state == BUSY);
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_wdata_o = mem_wdata;
    assign bus.grant_id_o  = grant_id;
    assign bus.ch_rdata_o  = rdata_q;
    assign bus.ch_ack_o    = (state == DONE) ? (NUM_CH'(1) << grant_id) : '0;
endmodule
